// File: rtl/reg_file_2r1w_if.sv
// rtl/reg_file_2r1w_if.sv - register file access bundle: write port, two read ports, bulk clear
interface reg_file_2r1w_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
);
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              re0;
    logic [ADDR_W-1:0] raddr0;
    logic [WIDTH-1:0]  rdata0;
    logic              rvalid0;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [WIDTH-1:0]  rdata1;
    logic              rvalid1;

    modport master (
        output clr, we, waddr, wdata, re0, raddr0, re1, raddr1,
        input  rdata0, rvalid0, rdata1, rvalid1
    );

    modport slave (
        input  clr, we, waddr, wdata, re0, raddr0, re1, raddr1,
        output rdata0, rvalid0, rdata1, rvalid1
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - DEPTH x WIDTH register file, one write port, two registered read ports
module reg_file_2r1w #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int READ_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_2r1w_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  vld;

    logic              wr_hit;
    logic [ADDR_W-1:0] ra   [2];
    logic [WIDTH-1:0]  rd_d [2];
    logic              rv_d [2];

    assign wr_hit = bus.we && !bus.clr && ({1'b0, bus.waddr} < DEPTH_L);
    assign ra[0]  = bus.raddr0;
    assign ra[1]  = bus.raddr1;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            vld <= '0;
        end else if (wr_hit) begin
            mem[bus.waddr] <= bus.wdata;
            vld[bus.waddr] <= 1'b1;
        end
    end

    // A clear wins over every read; write-through only bypasses a write that will actually land.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_d[p] = '0;
            rv_d[p] = 1'b0;
            if (!bus.clr && ({1'b0, ra[p]} < DEPTH_L)) begin
                if (READ_MODE == 1 && wr_hit && ra[p] == bus.waddr) begin
                    rd_d[p] = bus.wdata;
                    rv_d[p] = 1'b1;
                end else begin
                    rd_d[p] = mem[ra[p]];
                    rv_d[p] = vld[ra[p]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdata0  <= '0;
            bus.rvalid0 <= 1'b0;
            bus.rdata1  <= '0;
            bus.rvalid1 <= 1'b0;
        end else begin
            if (bus.re0) begin
                bus.rdata0  <= rd_d[0];
                bus.rvalid0 <= rv_d[0];
            end
            if (bus.re1) begin
                bus.rdata1  <= rd_d[1];
                bus.rvalid1 <= rv_d[1];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - scoreboard bench over read-old, write-through and DEPTH=6 instances
module tb_reg_file_2r1w;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    reg_file_2r1w_if #(.WIDTH(4), .ADDR_W(3)) b0 ();
    reg_file_2r1w_if #(.WIDTH(4), .ADDR_W(3)) b1 ();
    reg_file_2r1w_if #(.WIDTH(4), .ADDR_W(3)) b2 ();

    reg_file_2r1w #(.WIDTH(4), .DEPTH(8), .READ_MODE(0)) u_old (.clk(clk), .rst(rst), .bus(b0));
    reg_file_2r1w #(.WIDTH(4), .DEPTH(8), .READ_MODE(1)) u_thr (.clk(clk), .rst(rst), .bus(b1));
    reg_file_2r1w #(.WIDTH(4), .DEPTH(6), .READ_MODE(0)) u_d6  (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        int         cyc;
        int         dut;
        int         port;
        logic [3:0] d;
        logic       v;
        string      tag;
    } exp_t;

    exp_t q[$];

    task automatic drive(input logic c, input logic w, input logic [2:0] wa, input logic [3:0] wd,
                         input logic r0, input logic [2:0] a0, input logic r1, input logic [2:0] a1);
        b0.clr = c; b0.we = w; b0.waddr = wa; b0.wdata = wd;
        b0.re0 = r0; b0.raddr0 = a0; b0.re1 = r1; b0.raddr1 = a1;
        b1.clr = c; b1.we = w; b1.waddr = wa; b1.wdata = wd;
        b1.re0 = r0; b1.raddr0 = a0; b1.re1 = r1; b1.raddr1 = a1;
        b2.clr = c; b2.we = w; b2.waddr = wa; b2.wdata = wd;
        b2.re0 = r0; b2.raddr0 = a0; b2.re1 = r1; b2.raddr1 = a1;
    endtask

    task automatic ex(input int dut, input int port, input logic [3:0] d, input logic v, input string tag);
        exp_t e;
        e.cyc = cyc_cnt; e.dut = dut; e.port = port; e.d = d; e.v = v; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic ex_all(input int port, input logic [3:0] d, input logic v, input string tag);
        for (int k = 0; k < 3; k++) ex(k, port, d, v, tag);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [4:0] sample(input int dut, input int port);
        case (dut)
            0:       return (port == 0) ? {b0.rvalid0, b0.rdata0} : {b0.rvalid1, b0.rdata1};
            1:       return (port == 0) ? {b1.rvalid0, b1.rdata0} : {b1.rvalid1, b1.rdata1};
            default: return (port == 0) ? {b2.rvalid0, b2.rdata0} : {b2.rvalid1, b2.rdata1};
        endcase
    endfunction

    // Each expectation describes the outputs after the edge closing its issue cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc < cyc_cnt) begin
                exp_t       e;
                logic [4:0] got;
                e   = q.pop_front();
                got = sample(e.dut, e.port);
                total++;
                if (e.cyc != cyc_cnt - 1 || got != {e.v, e.d}) begin
                    bad++;
                    $display("FAIL %s dut%0d port%0d: got v=%0b d=0x%h, want v=%0b d=0x%h (issue cyc %0d, now %0d)",
                             e.tag, e.dut, e.port, got[4], got[3:0], e.v, e.d, e.cyc, cyc_cnt);
                end
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // reset with write and reads active
        rst = 1'b1;
        drive(0, 1, 0, 4'hF, 1, 0, 1, 0);
        ex_all(0, 4'h0, 1'b0, "reset"); ex_all(1, 4'h0, 1'b0, "reset");
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 1, 5);
        ex_all(0, 4'h0, 1'b0, "unwritten"); ex_all(1, 4'h0, 1'b0, "unwritten");
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 3'(i), 4'(i + 3), 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i));
            ex(0, 0, 4'(i + 3), 1'b1, "rd_all");
            ex(1, 0, 4'(i + 3), 1'b1, "rd_all");
            ex(0, 1, 4'(10 - i), 1'b1, "rd_all");
            ex(1, 1, 4'(10 - i), 1'b1, "rd_all");
            if (i < 6) ex(2, 0, 4'(i + 3), 1'b1, "rd_all");
            else       ex(2, 0, 4'h0, 1'b0, "rd_oor");
            if (7 - i < 6) ex(2, 1, 4'(10 - i), 1'b1, "rd_all");
            else           ex(2, 1, 4'h0, 1'b0, "rd_oor");
            tick();
        end

        drive(0, 1, 7, 4'hE, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 7, 1, 1);
        ex(0, 0, 4'hE, 1'b1, "wr7"); ex(1, 0, 4'hE, 1'b1, "wr7"); ex(2, 0, 4'h0, 1'b0, "wr_oor");
        ex_all(1, 4'h4, 1'b1, "wr_oor_alias");
        tick();

        drive(0, 1, 2, 4'hA, 1, 2, 1, 2);
        ex(0, 0, 4'h5, 1'b1, "coll"); ex(0, 1, 4'h5, 1'b1, "coll");
        ex(1, 0, 4'hA, 1'b1, "coll"); ex(1, 1, 4'hA, 1'b1, "coll");
        ex(2, 0, 4'h5, 1'b1, "coll"); ex(2, 1, 4'h5, 1'b1, "coll");
        tick();
        drive(0, 0, 0, 0, 1, 2, 1, 2);
        ex_all(0, 4'hA, 1'b1, "coll_after"); ex_all(1, 4'hA, 1'b1, "coll_after");
        tick();

        drive(0, 0, 0, 0, 1, 1, 0, 0);
        ex_all(0, 4'h4, 1'b1, "hold_rd"); ex_all(1, 4'hA, 1'b1, "hold_p1");
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 4'hF, 0, 0, 0, 0);
            ex_all(0, 4'h4, 1'b1, "hold");
            tick();
        end
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        ex_all(0, 4'hF, 1'b1, "hold_after");
        tick();

        drive(1, 1, 3, 4'h9, 1, 3, 1, 1);
        ex_all(0, 4'h0, 1'b0, "clr_same"); ex_all(1, 4'h0, 1'b0, "clr_same");
        tick();
        drive(0, 0, 0, 0, 1, 3, 1, 1);
        ex_all(0, 4'h0, 1'b0, "clr_after"); ex_all(1, 4'h0, 1'b0, "clr_after");
        tick();

        drive(0, 1, 4, 4'h7, 1, 4, 0, 0);
        ex(0, 0, 4'h0, 1'b0, "coll_inv"); ex(1, 0, 4'h7, 1'b1, "coll_inv"); ex(2, 0, 4'h0, 1'b0, "coll_inv");
        tick();
        drive(0, 1, 3, 4'h9, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 3, 1, 4);
        ex_all(0, 4'h9, 1'b1, "rewrite"); ex_all(1, 4'h7, 1'b1, "rewrite");
        tick();

        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        ex_all(0, 4'h0, 1'b0, "mid_rst"); ex_all(1, 4'h0, 1'b0, "mid_rst");
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 3, 1, 4);
        ex_all(0, 4'h0, 1'b0, "post_rst"); ex_all(1, 4'h0, 1'b0, "post_rst");
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 5 && q.size() > 0; k++) tick();
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file: DEPTH entries of WIDTH bits, one synchronous write port and two independent registered read ports. It extends the single-word read/write register to multiple addressable words, with per-entry valid tracking, a bulk clear, and a selectable read-during-write policy. It sits between datapath units that need several named storage words and is clocked on the single system clock.

## Interface

- WIDTH, 4: bits per entry (≥1)
- DEPTH, 8: number of entries (≥2, need not be a power of two)
- READ_MODE, 0: 0 = read-old (a read colliding with a same-cycle write returns the pre-write value); 1 = write-through (returns the new write data)
- ADDR_W (localparam): $clog2(DEPTH)

Ports:

- clk  in  1  system clock, all state on posedge
- rst  in  1  reset: synchronous, active-high
- clr  in  1  bulk clear of all entries and valid bits
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- re0  in  1  read enable, port 0
- raddr0  in  ADDR_W  read address, port 0
- rdata0  out  WIDTH  registered read data, port 0
- rvalid0  out  1  registered valid flag of the entry read on port 0
- re1, raddr1, rdata1, rvalid1: same as port 0, for port 1

## Operation

- Storage: mem[DEPTH] of WIDTH bits, plus vld[DEPTH].
- rst: all mem = 0, all vld = 0, rdata0/1 = 0, rvalid0/1 = 0. This takes priority over every other input.
- clr (with rst low): all mem = 0, all vld = 0. Any same-cycle write is dropped. A read in the same cycle returns 0 with rvalid = 0, in both modes.
- Write: if we && !clr && waddr < DEPTH, then mem[waddr] = wdata and vld[waddr] = 1.
- Write with waddr ≥ DEPTH is ignored and no entry changes.
- Read port p:
  - re_p = 1: rdata_p and rvalid_p are loaded from entry raddr_p.
  - re_p = 0: rdata_p and rvalid_p hold their previous values.
  - raddr_p ≥ DEPTH: rdata_p = 0, rvalid_p = 0.
- Collision (re_p && we && raddr_p == waddr, no clr):
  - READ_MODE 0: rdata_p = old mem[raddr_p], rvalid_p = old vld.
  - READ_MODE 1: rdata_p = wdata, rvalid_p = 1.
- Both ports may read the same address in the same cycle. The ports are fully independent.

## Timing

- Write latency: 1 cycle. Data written at edge N is readable by a read issued in cycle N+1, with result visible after edge N+1.
- Read latency: 1 cycle. Address presented in cycle N gives rdata after edge N, stable for the whole of cycle N+1.
- No combinational path from any input to rdata or rvalid.
- rst or clr asserted mid-stream: takes effect at the next edge. The cycle after, every read returns 0 with rvalid = 0 until the entry is rewritten.
- No handshake and no backpressure: every request is serviced in exactly one cycle.

## Test plan

1. **Reset:** assert rst with we = 1, re0 = re1 = 1. Required: rdata0/1 = 0 and rvalid0/1 = 0 after the edge, and no entry is written.
2. **Write/read all:** write mem[i] = i+3 for every i (WIDTH = 4, DEPTH = 8), then read i on port 0 and 7−i on port 1. Required: values match one cycle later, rvalid = 1.
3. **Collision:** mem[2] = 0x5; in the same cycle write 0xA to addr 2 and read addr 2 on both ports.
   - READ_MODE 0 required: rdata = 0x5; the next read returns 0xA.
   - READ_MODE 1 required: rdata = 0xA.
4. **Hold:** read addr 1 (value 0x4), then deassert re0 for 3 cycles while writing 0xF to addr 1. Required: rdata0 stays 0x4 throughout.
5. **Clear vs write:** assert clr and we (addr 3, 0x9) in the same cycle, then read addr 3. Required: rdata = 0, rvalid = 0. Read an unwritten address after reset: also 0 with rvalid = 0.
6. **Out of range:** DEPTH = 6; write addr 7 and read addr 6. Required: no entry changes, and the read returns rdata = 0, rvalid = 0.
